// File: rtl/ram_nport_wf_pkg.sv
// Shared defaults and FSM encoding for the 1-write / N-read
// write-first RAM.
package ram_nport_wf_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_READ   = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_nport_wf_dpram.sv
// Simple dual-port RAM: port A writes, port B reads into
// an enable-gated output register.
module ram_nport_wf_dpram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_re,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_data;
        end
    end

    // Read-first: a same-address write is resolved by the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_data <= '0;
        end else if (b_re) begin
            b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ram_nport_wf.sv
// 1-write / N-read synchronous RAM with write-first bypass,
// per-port read_valid and a post-reset clear sweep.
module ram_nport_wf
    import ram_nport_wf_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_READ      = DEF_NUM_READ,
    parameter int INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           init_busy,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [NUM_READ-1:0]            read_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_valid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam state_e RST_STATE =
        (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_e                state_q;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  run;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_READ-1:0]   rd_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        init_busy = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // Counter parks on the last address; only reset rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT && cnt_q != LAST_ADDR) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign run     = (state_q == ST_RUN);
    assign wr_en   = run ? write_en : 1'b1;
    assign wr_addr = run ? write_addr : cnt_q;
    assign wr_data = run ? write_data : INIT_VALUE;
    assign rd_go   = read_en & {NUM_READ{run}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid <= '0;
        end else begin
            read_valid <= rd_go;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] ram_q;
        logic [DATA_WIDTH-1:0] byp_data_q;
        logic                  byp_q;
        logic                  hit;

        assign raddr = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit   = run && write_en && (write_addr == raddr);

        ram_nport_wf_dpram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk    (clk),
            .rst_n  (rst_n),
            .a_we   (wr_en),
            .a_addr (wr_addr),
            .a_data (wr_data),
            .b_re   (rd_go[i]),
            .b_addr (raddr),
            .b_data (ram_q)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                byp_q      <= 1'b0;
                byp_data_q <= '0;
            end else if (rd_go[i]) begin
                byp_q      <= hit;
                byp_data_q <= write_data;
            end
        end

        assign read_data[i*DATA_WIDTH +: DATA_WIDTH] =
            byp_q ? byp_data_q : ram_q;
    end

endmodule

// File: tb/tb_ram_nport_wf.sv
// Directed scoreboard bench for ram_nport_wf with 16 x 16-bit
// entries and three read ports.
module tb_ram_nport_wf;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NR = 3;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] IV = 16'hA5A5;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             init_busy;
    logic             write_en = 1'b0;
    logic [AW-1:0]    write_addr = '0;
    logic [DW-1:0]    write_data = '0;
    logic [NR-1:0]    read_en = '0;
    logic [NR*AW-1:0] read_addr = '0;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0]    read_valid;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last [NR];

    ram_nport_wf #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .NUM_READ      (NR),
        .INIT_ON_RESET (1),
        .INIT_VALUE    (IV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_busy  (init_busy),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_valid (read_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RUN-mode cycle: drive, predict, clock, compare.
    task automatic step(input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NR-1:0] ren,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
        logic [AW-1:0] ra [NR];
        exp_t e;
        ra[0] = a0;
        ra[1] = a1;
        ra[2] = a2;
        write_en   = we;
        write_addr = wa;
        write_data = wd;
        read_en    = ren;
        read_addr  = {a2, a1, a0};
        for (int i = 0; i < NR; i++) begin
            e.port = i;
            if (ren[i]) begin
                e.data = (we && wa == ra[i]) ? wd : model[ra[i]];
            end else begin
                e.data = last[i];
            end
            last[i] = e.data;
            sb.push_back(e);
        end
        if (we) model[wa] = wd;
        tick();
        write_en = 1'b0;
        read_en  = '0;
        check("read_valid", 64'(read_valid), 64'(ren));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("read_data[%0d]", e.port),
                  64'(read_data[e.port*DW +: DW]), 64'(e.data));
        end
    endtask

    task automatic sweep_wait(input bit poke);
        int n;
        n = 0;
        while (init_busy && n < 40) begin
            if (poke) begin
                write_en   = 1'b1;
                write_addr = AW'(n);
                write_data = 16'hDEAD;
                read_en    = '1;
                read_addr  = {3{AW'(n)}};
            end
            n++;
            tick();
            check("valid_in_sweep", 64'(read_valid), 64'(0));
        end
        write_en = 1'b0;
        read_en  = '0;
        check("init_busy_cycles", 64'(n), 64'(DEPTH));
        for (int a = 0; a < DEPTH; a++) model[a] = IV;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, '0, '0, 3'b111, AW'(a), AW'(a), AW'(a));
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) last[i] = '0;
        tick();
        check("reset_busy", 64'(init_busy), 64'(1));
        check("reset_valid", 64'(read_valid), 64'(0));
        check("reset_data", 64'(read_data), 64'(0));
        tick();
        rst_n = 1'b1;

        // Sweep with writes and reads asserted; both must be ignored.
        sweep_wait(1'b1);
        read_all();

        step(1'b1, 4'h3, 16'h1234, 3'b000, 4'h0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 16'h0000, 3'b111, 4'h3, 4'h3, 4'h3);

        step(1'b1, 4'h7, 16'hBEEF, 3'b110, 4'h0, 4'h7, 4'h8);
        step(1'b0, 4'h0, 16'h0000, 3'b111, 4'h7, 4'h7, 4'h7);

        step(1'b0, 4'h0, 16'h0000, 3'b101, 4'h1, 4'h2, 4'h1);

        // Reset in the middle of a sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        check("mid_sweep_busy", 64'(init_busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 64'(read_data), 64'(0));
        check("mid_rst_valid", 64'(read_valid), 64'(0));
        check("mid_rst_busy", 64'(init_busy), 64'(1));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) last[i] = '0;
        sweep_wait(1'b0);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
